// File: rtl/hack_cpu_seq.sv
// rtl/hack_cpu_seq.sv - multi-cycle Hack-ISA sequencer driving an external 16-bit ALU
module hack_cpu_seq (
    input  logic        clk,
    input  logic        rst,
    output logic        instr_req,
    output logic [14:0] instr_addr,
    input  logic        instr_ack,
    input  logic [15:0] instr_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    output logic [14:0] pc,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEMRD, EXEC, WB} state_t;

    state_t      state, state_nxt;
    logic [15:0] ir, m_reg, r_reg;
    logic [14:0] aold;
    logic        take;
    logic [14:0] pc_inc;
    logic        wr_pending;
    logic        wb_done;
    logic        r_neg;

    assign pc_inc     = pc + 15'd1;
    assign wr_pending = (state == WB) && ir[3];
    assign wb_done    = (state == WB) && (!ir[3] || mem_ack);
    assign r_neg      = alu_out[15];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
            a_reg <= '0;
            d_reg <= '0;
            ir    <= '0;
            m_reg <= '0;
            r_reg <= '0;
            aold  <= '0;
            take  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                FETCH: if (instr_ack) ir <= instr_data;
                DECODE: begin
                    if (!ir[15]) begin
                        a_reg <= {1'b0, ir[14:0]};
                        pc    <= pc_inc;
                    end
                end
                MEMRD: if (mem_ack) m_reg <= mem_rdata;
                EXEC: begin
                    r_reg <= alu_out;
                    take  <= (ir[2] & r_neg) | (ir[1] & alu_zr) | (ir[0] & !r_neg & !alu_zr);
                    aold  <= a_reg[14:0];
                end
                WB: begin
                    // Jump target and write address come from aold, so a new A never leaks in
                    if (wb_done) begin
                        if (ir[5]) a_reg <= r_reg;
                        if (ir[4]) d_reg <= r_reg;
                        pc <= take ? aold : pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = FETCH;
            FETCH:  if (instr_ack) state_nxt = DECODE;
            DECODE: begin
                if (!ir[15])    state_nxt = FETCH;
                else if (ir[12]) state_nxt = MEMRD;
                else            state_nxt = EXEC;
            end
            MEMRD:  if (mem_ack) state_nxt = EXEC;
            EXEC:   state_nxt = WB;
            WB:     if (wb_done) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        instr_req  = (state == FETCH);
        instr_addr = pc;
        mem_req    = (state == MEMRD) || wr_pending;
        mem_we     = wr_pending;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state == MEMRD) begin
            mem_addr = a_reg[14:0];
        end else if (wr_pending) begin
            mem_addr  = aold;
            mem_wdata = r_reg;
        end
    end

    assign alu_x  = d_reg;
    assign alu_y  = ir[12] ? m_reg : a_reg;
    assign alu_zx = ir[11];
    assign alu_nx = ir[10];
    assign alu_zy = ir[9];
    assign alu_ny = ir[8];
    assign alu_f  = ir[7];
    assign alu_no = ir[6];

endmodule

// File: tb/tb_hack_cpu_seq.sv
// tb/tb_hack_cpu_seq.sv - self-checking bench for hack_cpu_seq
module tb_hack_cpu_seq;

    logic        clk, rst;
    logic        instr_req, instr_ack;
    logic [14:0] instr_addr;
    logic [15:0] instr_data;
    logic        mem_req, mem_we, mem_ack;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr;
    logic [14:0] pc;
    logic [15:0] a_reg, d_reg;

    hack_cpu_seq dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_data(instr_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr),
        .pc(pc), .a_reg(a_reg), .d_reg(d_reg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference Hack ALU
    logic [15:0] ax1, ax2, ay1, ay2, ao;
    always_comb begin
        ax1 = alu_zx ? 16'h0 : alu_x;
        ax2 = alu_nx ? ~ax1 : ax1;
        ay1 = alu_zy ? 16'h0 : alu_y;
        ay2 = alu_ny ? ~ay1 : ay1;
        ao  = alu_f ? (ax2 + ay2) : (ax2 & ay2);
        alu_out = alu_no ? ~ao : ao;
        alu_zr  = (alu_out == 16'h0);
    end

    logic [15:0] imem [0:32767];
    logic [15:0] dmem [0:32767];

    int checks = 0;
    int errors = 0;

    int          mem_wait;
    bit          mem_en;
    int          mcnt;
    int          rd_cnt, wr_cnt, unstable;
    logic [14:0] rd_first, wr_addr_last, pw_addr;
    logic [15:0] wr_data_last, pw_data;
    bit          pw_valid;

    always @(negedge clk) begin
        instr_ack  = instr_req;
        instr_data = instr_req ? imem[instr_addr] : 16'h0;
    end

    // Data memory with programmable ack latency; also watches write-request stability
    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_req) begin
                mem_ack = (mcnt >= mem_wait);
                if (mem_ack) mcnt = 0; else mcnt++;
                if (!mem_we) begin
                    mem_rdata = dmem[mem_addr];
                    if (mem_ack) begin
                        if (rd_cnt == 0) rd_first = mem_addr;
                        rd_cnt++;
                    end
                end else begin
                    if (pw_valid && (mem_addr != pw_addr || mem_wdata != pw_data)) unstable++;
                    pw_valid = !mem_ack;
                    pw_addr  = mem_addr;
                    pw_data  = mem_wdata;
                    if (mem_ack) begin
                        dmem[mem_addr] = mem_wdata;
                        wr_addr_last   = mem_addr;
                        wr_data_last   = mem_wdata;
                        wr_cnt++;
                    end
                end
            end else begin
                mem_ack  = 1'b0;
                mcnt     = 0;
                pw_valid = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0][15:0] prog;
        int               n;
        int               mwait;
        logic [14:0]      exp_pc;
        logic [15:0]      exp_a;
        logic [15:0]      exp_d;
        int               exp_cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic load_and_run(input int idx);
        int fetched, cyc;
        bit done;
        for (int i = 0; i < 16; i++) imem[i] = 16'h0;
        for (int i = 0; i < 4; i++) imem[i] = vecs[idx].prog[i];
        imem[15'h7FFF] = 16'h0001;
        dmem[100] = 16'd7;
        mem_wait = vecs[idx].mwait;
        mem_en = 1; mcnt = 0; rd_cnt = 0; wr_cnt = 0; unstable = 0; pw_valid = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        fetched = 0; cyc = 0; done = 0;
        while (!done && cyc < 300) begin
            if (instr_req) begin
                if (fetched == vecs[idx].n) done = 1;
                else fetched++;
            end
            if (!done) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check($sformatf("vec%0d_done", idx), {31'h0, done}, 32'h1);
        check($sformatf("vec%0d_cycles", idx), cyc, vecs[idx].exp_cyc);
        check($sformatf("vec%0d_pc", idx), {17'h0, pc}, {17'h0, vecs[idx].exp_pc});
        check($sformatf("vec%0d_a", idx), {16'h0, a_reg}, {16'h0, vecs[idx].exp_a});
        check($sformatf("vec%0d_d", idx), {16'h0, d_reg}, {16'h0, vecs[idx].exp_d});
    endtask

    initial begin
        int cyc;
        rst = 1'b1; instr_ack = 0; instr_data = 0; mem_ack = 0; mem_rdata = 0;
        mem_en = 1; mem_wait = 0; mcnt = 0; pw_valid = 0;
        rd_cnt = 0; wr_cnt = 0; unstable = 0;
        rd_first = 0; wr_addr_last = 0; wr_data_last = 0; pw_addr = 0; pw_data = 0;
        for (int i = 0; i < 32768; i++) begin imem[i] = 16'h0; dmem[i] = 16'h0; end

        vecs[0] = '{prog: {16'hE090, 16'h0003, 16'hEC10, 16'h0005}, n: 4, mwait: 0,
                    exp_pc: 15'd4, exp_a: 16'd3, exp_d: 16'd8, exp_cyc: 12};
        vecs[1] = '{prog: {16'h0, 16'h0, 16'hEA82, 16'h000A}, n: 2, mwait: 0,
                    exp_pc: 15'd10, exp_a: 16'd10, exp_d: 16'd0, exp_cyc: 6};
        vecs[2] = '{prog: {16'h0, 16'h0, 16'hEA84, 16'h000A}, n: 2, mwait: 0,
                    exp_pc: 15'd2, exp_a: 16'd10, exp_d: 16'd0, exp_cyc: 6};
        vecs[3] = '{prog: {16'h0, 16'h0, 16'hEAA7, 16'h000A}, n: 2, mwait: 0,
                    exp_pc: 15'd10, exp_a: 16'd0, exp_d: 16'd0, exp_cyc: 6};
        vecs[4] = '{prog: {16'h0, 16'h0, 16'hEA87, 16'h7FFF}, n: 3, mwait: 0,
                    exp_pc: 15'd0, exp_a: 16'd1, exp_d: 16'd0, exp_cyc: 8};
        vecs[5] = '{prog: {16'h0, 16'h0, 16'hFC10, 16'h0064}, n: 2, mwait: 0,
                    exp_pc: 15'd2, exp_a: 16'd100, exp_d: 16'd7, exp_cyc: 7};
        vecs[6] = '{prog: {16'hF088, 16'h0064, 16'hEC10, 16'h0008}, n: 4, mwait: 2,
                    exp_pc: 15'd4, exp_a: 16'd100, exp_d: 16'd8, exp_cyc: 17};

        // Reset: two cycles, then IDLE with everything at zero, then first fetch at 0
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("idle_ctrl", {26'h0, instr_req, mem_req, mem_we, alu_zx, alu_nx, alu_zy}, 32'h0);
        check("idle_alu_ctrl", {29'h0, alu_ny, alu_f, alu_no}, 32'h0);
        check("idle_addrs", {2'b0, instr_addr, 15'h0} | {17'h0, mem_addr}, 32'h0);
        check("idle_data", {mem_wdata, alu_x}, 32'h0);
        check("idle_regs", {alu_y, a_reg} | {16'h0, d_reg} | {17'h0, pc}, 32'h0);
        @(posedge clk); #1;
        check("first_instr_req", {31'h0, instr_req}, 32'h1);
        check("first_instr_addr", {17'h0, instr_addr}, 32'h0);

        for (int v = 0; v < 7; v++) load_and_run(v);

        // vecs[6] was the delayed M read/write: inspect the memory traffic it produced
        check("mrw_read_cnt", rd_cnt, 1);
        check("mrw_read_addr", {17'h0, rd_first}, 32'd100);
        check("mrw_write_cnt", wr_cnt, 1);
        check("mrw_write_addr", {17'h0, wr_addr_last}, 32'd100);
        check("mrw_write_data", {16'h0, wr_data_last}, 32'd15);
        check("mrw_stable", unstable, 0);

        // Reset while a write is held in WB: request drops, late ack is ignored
        for (int i = 0; i < 16; i++) imem[i] = 16'h0;
        imem[0] = 16'h0064;
        imem[1] = 16'hEA88;
        mem_wait = 1000; mem_en = 1; mcnt = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        while (!(mem_req && mem_we) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("wb_write_reached", {31'h0, mem_req & mem_we}, 32'h1);
        check("wb_write_addr", {17'h0, mem_addr}, 32'd100);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_drops_mem_req", {31'h0, mem_req}, 32'h0);
        mem_en = 0;
        mem_ack = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("late_ack_mem_req", {31'h0, mem_req}, 32'h0);
        check("late_ack_regs", {a_reg, d_reg}, 32'h0);
        check("late_ack_pc", {17'h0, pc}, 32'h0);
        check("late_ack_fetch", {31'h0, instr_req}, 32'h1);
        mem_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
